lmg_move_sequencer: RTL and testbench

//  Sequences one move-generation pass and drains its 160-bit move FIFO. Restarts the

---
 rtl/lmg_move_sequencer.sv | 175 +++++++++++++++++
 tb/tb_lmg_move_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmg_move_sequencer.sv
// Runs one legal-move generation pass, drains the packed move FIFO, and hands the
// valid moves one at a time to the search/eval consumer over a valid/ready handshake.
module lmg_move_sequencer #(
  parameter int unsigned SLOTS       = 8,
  parameter int unsigned MOVE_W      = 19,
  parameter int unsigned WORD_W      = 160,
  parameter int unsigned INV_BIT     = 18,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned EMPTY_GUARD = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               gen_reset,
  input  logic               gen_done,
  input  logic               fifo_empty,
  input  logic [WORD_W-1:0]  fifo_q,
  output logic               fifo_rden,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic [6:0]         mv_flags,
  output logic [5:0]         mv_from,
  output logic [5:0]         mv_to,
  output logic [COUNT_W-1:0] mv_count,
  output logic               busy,
  output logic               pass_done
);

  localparam int unsigned PAY_W   = SLOTS * MOVE_W;
  localparam int unsigned IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned GUARD_W = (EMPTY_GUARD > 1) ? $clog2(EMPTY_GUARD + 1) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(SLOTS - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(EMPTY_GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_WAIT,
    S_READ,
    S_LOAD,
    S_EMIT,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [PAY_W-1:0]   r_word;
  logic [IDX_W-1:0]   r_idx;
  logic [GUARD_W-1:0] r_guard;
  logic [COUNT_W-1:0] r_count;
  logic               r_gen_reset;
  logic               r_rden;
  logic               r_busy;
  logic               r_pass_done;

  logic [MOVE_W-1:0]  w_slot;
  logic               w_inv;
  logic               w_emit;
  logic               w_take;
  logic               w_last;
  logic               w_unused_spare;

  // Spare bits above the packed slots carry nothing for this block.
  assign w_unused_spare = ^fifo_q[WORD_W-1:PAY_W];

  // Slot 0 sits in the MSBs of the payload.
  always_comb begin
    w_slot = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_slot = r_word[(SLOTS-1-k)*MOVE_W +: MOVE_W];
      end
    end
  end

  assign w_inv  = w_slot[INV_BIT];
  assign w_emit = (r_state == S_EMIT);
  assign w_take = w_emit && (w_inv || mv_ready);
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_idx       <= '0;
      r_guard     <= '0;
      r_count     <= '0;
      r_gen_reset <= 1'b1;
      r_rden      <= 1'b0;
      r_busy      <= 1'b0;
      r_pass_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RST;
          end
        end
        S_RST: begin
          r_gen_reset <= 1'b0;
          r_guard     <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // gen_done can lead the final write; only a run of empty cycles ends the pass.
          if (!fifo_empty) begin
            r_guard <= '0;
            r_rden  <= 1'b1;
            r_state <= S_READ;
          end else if (gen_done) begin
            if (r_guard == GUARD_LAST) begin
              r_guard     <= '0;
              r_pass_done <= 1'b1;
              r_state     <= S_FIN;
            end else begin
              r_guard <= r_guard + 1'b1;
            end
          end else begin
            r_guard <= '0;
          end
        end
        S_READ: begin
          r_rden  <= 1'b0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_word  <= fifo_q[PAY_W-1:0];
          r_idx   <= '0;
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (w_take) begin
            if (!w_inv && (r_count != '1)) begin
              r_count <= r_count + 1'b1;
            end
            if (w_last) begin
              r_idx <= '0;
              if (!fifo_empty) begin
                r_rden  <= 1'b1;
                r_state <= S_READ;
              end else begin
                r_guard <= '0;
                r_state <= S_WAIT;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_FIN: begin
          r_pass_done <= 1'b0;
          r_busy      <= 1'b0;
          r_gen_reset <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gen_reset = r_gen_reset;
  assign fifo_rden = r_rden;
  assign busy      = r_busy;
  assign pass_done = r_pass_done;
  assign mv_count  = r_count;
  assign mv_valid  = w_emit && !w_inv;
  assign mv_flags  = w_slot[18:12];
  assign mv_from   = w_slot[11:6];
  assign mv_to     = w_slot[5:0];

endmodule

// File: tb/tb_lmg_move_sequencer.sv
// Directed bench for lmg_move_sequencer: a FIFO/generator model feeds packed words, a
// scoreboard queue holds the expected moves, and a negedge monitor checks each transfer.
module tb_lmg_move_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         gen_done = 1'b0;
  logic         mv_ready = 1'b1;
  logic         fifo_empty;
  logic [159:0] fifo_q = '0;

  logic         gen_reset, fifo_rden, mv_valid, busy, pass_done;
  logic [6:0]   mv_flags;
  logic [5:0]   mv_from, mv_to;
  logic [7:0]   mv_count;

  logic         u4_gen_reset, u4_fifo_rden, u4_mv_valid, u4_busy, u4_pass_done;
  logic [6:0]   u4_mv_flags;
  logic [5:0]   u4_mv_from, u4_mv_to;
  logic [3:0]   c4_count;

  lmg_move_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .gen_reset(gen_reset),
    .gen_done(gen_done), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rden(fifo_rden), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_flags(mv_flags), .mv_from(mv_from), .mv_to(mv_to),
    .mv_count(mv_count), .busy(busy), .pass_done(pass_done)
  );

  // Narrow-counter twin fed in lockstep; only its counter is checked.
  lmg_move_sequencer #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .gen_reset(u4_gen_reset),
    .gen_done(gen_done), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rden(u4_fifo_rden), .mv_valid(u4_mv_valid), .mv_ready(mv_ready),
    .mv_flags(u4_mv_flags), .mv_from(u4_mv_from), .mv_to(u4_mv_to),
    .mv_count(c4_count), .busy(u4_busy), .pass_done(u4_pass_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Generator FIFO model: normal read mode, cleared while gen_reset is high.
  logic [159:0] fmem[$];
  int           fcnt = 0;
  logic         wr_en = 1'b0;
  logic [159:0] wr_data = '0;

  assign fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (gen_reset) begin
      fmem.delete();
    end else begin
      if (fifo_rden && fmem.size() > 0) fifo_q <= fmem.pop_front();
      if (wr_en) fmem.push_back(wr_data);
    end
    fcnt <= fmem.size();
  end

  // Scoreboard and monitor
  logic [18:0] sb[$];
  int          xfer_cnt  = 0;
  int          pd_cnt    = 0;
  int          first_rd  = -1;
  int          first_val = -1;
  bit          hold_pend = 1'b0;
  logic [18:0] held      = '0;

  always @(negedge clk) begin
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        chk("stall_hold", {12'd0, mv_valid, mv_flags, mv_from, mv_to}, {12'd0, 1'b1, held});
      if (mv_valid && mv_ready) begin
        xfer_cnt++;
        chk("sb_nonempty_at_xfer", (sb.size() > 0), 1);
        if (sb.size() > 0) chk("move", {13'd0, mv_flags, mv_from, mv_to}, {13'd0, sb.pop_front()});
      end
      hold_pend = mv_valid && !mv_ready;
      held      = {mv_flags, mv_from, mv_to};
      if (pass_done) pd_cnt++;
      if (fifo_rden && first_rd < 0) first_rd = cyc;
      if (mv_valid && first_val < 0) first_val = cyc;
    end
  end

  // Stimulus helpers
  logic [18:0] slot_v[8];
  bit          slot_ok[8];
  int          start_cyc = 0;
  int          pd0 = 0;

  task automatic mk_word(input int kind);
    for (int k = 0; k < 8; k++) begin
      case (kind)
        1: begin slot_v[k] = {7'h00, 3'(k), 3'o1, 3'(k), 3'o2}; slot_ok[k] = 1'b1; end
        2: begin slot_v[k] = {(k == 7) ? 7'h05 : 7'h00, 3'(k), 3'o3, 3'(k), 3'o4}; slot_ok[k] = 1'b1; end
        3: begin
          if (k < 4) begin slot_v[k] = {7'h00, 3'(k + 1), 3'o0, 3'(k), 3'o2}; slot_ok[k] = 1'b1; end
          else       begin slot_v[k] = {7'h40, 3'(k), 3'o7, 3'o7, 3'(k)};     slot_ok[k] = 1'b0; end
        end
        4: begin slot_v[k] = {7'h40, 3'(k), 3'o5, 3'(k), 3'o6}; slot_ok[k] = 1'b0; end
        5: begin slot_v[k] = {7'h00, 3'o6, 3'(k), 3'o5, 3'(k)}; slot_ok[k] = 1'b1; end
        default: begin slot_v[k] = {7'h01, 3'(k), 3'o2, 3'(k), 3'o3}; slot_ok[k] = 1'b1; end
      endcase
    end
  endtask

  task automatic push_word();
    logic [151:0] pay;
    pay = '0;
    for (int k = 0; k < 8; k++) begin
      pay = {pay[132:0], slot_v[k]};
      if (slot_ok[k]) sb.push_back(slot_v[k]);
    end
    wr_data = {8'hA5, pay};
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic begin_pass();
    int n;
    gen_done  = 1'b0;
    first_rd  = -1;
    first_val = -1;
    xfer_cnt  = 0;
    pd0       = pd_cnt;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (gen_reset && n < 10) begin tick(); n++; end
    chk("gen_reset_released", gen_reset, 0);
  endtask

  task automatic wait_pass(input int exp_cnt);
    int n;
    n = 0;
    while (!pass_done && n < 600) begin tick(); n++; end
    chk("pass_done_seen", pass_done, 1);
    chk("mv_count", mv_count, exp_cnt);
    chk("mv_count_sat4", c4_count, (exp_cnt > 15) ? 15 : exp_cnt);
    chk("sb_drained", sb.size(), 0);
    tick();
    chk("busy_idle", busy, 0);
    chk("gen_reset_idle", gen_reset, 1);
    tick();
    tick();
    chk("pass_done_pulses", pd_cnt - pd0, 1);
  endtask

  task automatic run_three_words(input bit stall);
    int n;
    begin_pass();
    mk_word(1); push_word();
    mk_word(2); push_word();
    mk_word(3); push_word();
    gen_done = 1'b1;
    if (stall) begin
      n = 0;
      while (xfer_cnt < 2 && n < 100) begin tick(); n++; end
      chk("stall_armed", xfer_cnt, 2);
      mv_ready = 1'b0;
      repeat (5) tick();
      chk("stall_no_xfer", xfer_cnt, 2);
      mv_ready = 1'b1;
    end
    wait_pass(20);
    chk("start_to_rden_ge3", ((first_rd - start_cyc) >= 3), 1);
    chk("load_to_valid", first_val - first_rd, 2);
  endtask

  initial begin : stim
    int n;
    int vcnt;
    int pd_before;

    // Reset state
    tick(); tick();
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_fifo_rden", fifo_rden, 0);
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_mv_count", mv_count, 0);
    reset = 1'b1;
    tick(); tick();
    chk("idle_gen_reset", gen_reset, 1);
    chk("idle_busy", busy, 0);

    // Three words, consumer always ready; then with a 5-cycle stall at move 3
    run_three_words(1'b0);
    run_three_words(1'b1);

    // All-invalid word followed by a fully valid word
    begin_pass();
    mk_word(4); push_word();
    mk_word(5); push_word();
    n = 0;
    while (!fifo_rden && n < 50) begin tick(); n++; end
    chk("inv_first_rden", fifo_rden, 1);
    n = 0; vcnt = 0;
    do begin
      tick(); n++;
      if (mv_valid) vcnt++;
    end while (!fifo_rden && n < 50);
    chk("inv_word_cycles", n, 10);
    chk("inv_word_silent", vcnt, 0);
    gen_done = 1'b1;
    wait_pass(8);

    // gen_done rises one cycle before the last word lands in the FIFO
    begin_pass();
    mk_word(1); push_word();
    repeat (16) tick();
    gen_done = 1'b1;
    mk_word(6); push_word();
    wait_pass(16);

    // start while busy is ignored; async reset mid-EMIT
    mv_ready = 1'b0;
    begin_pass();
    mk_word(5); push_word();
    n = 0;
    while (!mv_valid && n < 50) begin tick(); n++; end
    chk("s5_valid", mv_valid, 1);
    mv_ready = 1'b1;
    repeat (3) tick();
    mv_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mv_ready = 1'b1;
    repeat (2) tick();
    mv_ready = 1'b0;
    tick(); tick();
    chk("s5_count_kept", mv_count, 5);
    chk("s5_busy", busy, 1);
    chk("s5_valid_held", mv_valid, 1);
    pd_before = pd_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mv_valid", mv_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gen_reset", gen_reset, 1);
    chk("arst_fifo_rden", fifo_rden, 0);
    chk("arst_mv_count", mv_count, 0);
    chk("arst_pass_done", pass_done, 0);
    sb.delete();
    gen_done = 1'b0;
    mv_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("arst_no_pass_done", pd_cnt - pd_before, 0);
    chk("arst_idle_gen_reset", gen_reset, 1);
    run_three_words(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
